sdram_req_queue: RTL and testbench

SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

---
 rtl/sdram_req_queue.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_req_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_queue.sv
// rtl/sdram_req_queue.sv - request FIFO and issue sequencer feeding a single-port SDRAM controller
// Optional feature macro: REQ_TIMEOUT_EN (per-edge wait timeout with sticky ERR output)
module sdram_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       CLK,
  input  logic                       NRST,
  input  logic                       HOST_VALID,
  output logic                       HOST_READY,
  input  logic                       HOST_WR,
  input  logic [1:0]                 HOST_BANK,
  input  logic [12:0]                HOST_ROW,
  input  logic [8:0]                 HOST_COL,
  input  logic [15:0]                HOST_WDATA,
  output logic [15:0]                RD_DATA,
  output logic                       RD_VALID,
  output logic [12:0]                MEM_ADR,
  output logic [1:0]                 MEM_BDR,
  output logic [15:0]                MEM_DIN,
  output logic                       MEM_RE,
  output logic                       MEM_WE,
  input  logic                       MEM_RDY,
  input  logic [15:0]                MEM_DOUT,
  output logic [$clog2(DEPTH):0]     FIFO_LEVEL,
  output logic                       BUSY
`ifdef REQ_TIMEOUT_EN
  ,
  output logic                       ERR
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef struct packed {
    logic        wr;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] wdata;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_GAP,
    S_COL,
    S_WAIT
  } state_t;

  req_t            fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  req_t            head;
  logic            push;
  logic            pop;
  logic            adv;
  state_t          state;
  logic            hold_wr;
  logic [8:0]      hold_col;

  assign HOST_READY = NRST && (FIFO_LEVEL != FULL_LEVEL);
  assign push       = HOST_VALID && HOST_READY;
  assign pop        = (state == S_IDLE) && (FIFO_LEVEL != '0) && MEM_RDY;
  assign head       = fifo_mem[rd_ptr];
  assign BUSY       = (state != S_IDLE);

  // The MEM_RDY edge each state is waiting for; in S_IDLE it is the pop itself
  always_comb begin
    adv = 1'b0;
    case (state)
      S_IDLE:  adv = pop;
      S_ROW:   adv = !MEM_RDY;
      S_GAP:   adv = MEM_RDY;
      S_COL:   adv = !MEM_RDY;
      S_WAIT:  adv = MEM_RDY;
      default: adv = 1'b0;
    endcase
  end

`ifdef REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout;

  assign timeout = (state != S_IDLE) && (wait_cnt == CW'(TIMEOUT - 1));

  // Cycles spent waiting on the current MEM_RDY edge; restarts on every state change
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wait_cnt <= '0;
    end else if (state == S_IDLE || adv || timeout) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`endif

  // FIFO storage is data-only and needs no reset; occupancy lives in the pointers
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{wr: HOST_WR, bank: HOST_BANK, row: HOST_ROW,
                             col: HOST_COL, wdata: HOST_WDATA};
    end
  end

  // FIFO pointers and occupancy, independent of the sequencer state
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      FIFO_LEVEL <= FIFO_LEVEL + LW'(1);
      else if (pop && !push) FIFO_LEVEL <= FIFO_LEVEL - LW'(1);
    end
  end

  // Issue sequencer: follows the controller's MEM_RDY handshake and drives registered MEM_* outputs
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state    <= S_IDLE;
      hold_wr  <= 1'b0;
      hold_col <= '0;
      MEM_ADR  <= '0;
      MEM_BDR  <= '0;
      MEM_DIN  <= '0;
      MEM_RE   <= 1'b0;
      MEM_WE   <= 1'b0;
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      ERR      <= 1'b0;
`endif
    end else begin
      RD_VALID <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      if (timeout) begin
        state   <= S_IDLE;
        MEM_ADR <= '0;
        MEM_BDR <= '0;
        MEM_DIN <= '0;
        MEM_RE  <= 1'b0;
        MEM_WE  <= 1'b0;
        ERR     <= 1'b1;
      end else
`endif
      begin
        case (state)
          S_IDLE: begin
            if (adv) begin
              state    <= S_ROW;
              hold_wr  <= head.wr;
              hold_col <= head.col;
              MEM_ADR  <= head.row;
              MEM_BDR  <= head.bank;
              MEM_DIN  <= head.wdata;
              MEM_RE   <= !head.wr;
              MEM_WE   <= head.wr;
            end
          end
          S_ROW: begin
            if (adv) begin
              state   <= S_GAP;
              MEM_ADR <= {4'b0, hold_col};
            end
          end
          S_GAP: begin
            if (adv) state <= S_COL;
          end
          S_COL: begin
            if (adv) begin
              state   <= S_WAIT;
              MEM_ADR <= '0;
              MEM_BDR <= '0;
              MEM_DIN <= '0;
              MEM_RE  <= 1'b0;
              MEM_WE  <= 1'b0;
            end
          end
          S_WAIT: begin
            if (adv) begin
              state <= S_IDLE;
              if (!hold_wr) begin
                RD_DATA  <= MEM_DOUT;
                RD_VALID <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb/tb_sdram_req_queue.sv - self-checking bench for sdram_req_queue with controller model and scoreboard
module tb_sdram_req_queue;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        HOST_VALID = 1'b0;
  logic        HOST_READY;
  logic        HOST_WR = 1'b0;
  logic [1:0]  HOST_BANK = '0;
  logic [12:0] HOST_ROW = '0;
  logic [8:0]  HOST_COL = '0;
  logic [15:0] HOST_WDATA = '0;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic [12:0] MEM_ADR;
  logic [1:0]  MEM_BDR;
  logic [15:0] MEM_DIN;
  logic        MEM_RE;
  logic        MEM_WE;
  logic        MEM_RDY = 1'b1;
  logic [15:0] MEM_DOUT = '0;
  logic [2:0]  FIFO_LEVEL;
  logic        BUSY;
`ifdef REQ_TIMEOUT_EN
  logic        ERR;
`endif

  sdram_req_queue #(.DEPTH(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .NRST(NRST),
    .HOST_VALID(HOST_VALID), .HOST_READY(HOST_READY), .HOST_WR(HOST_WR),
    .HOST_BANK(HOST_BANK), .HOST_ROW(HOST_ROW), .HOST_COL(HOST_COL), .HOST_WDATA(HOST_WDATA),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .MEM_ADR(MEM_ADR), .MEM_BDR(MEM_BDR), .MEM_DIN(MEM_DIN), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_RDY(MEM_RDY), .MEM_DOUT(MEM_DOUT),
    .FIFO_LEVEL(FIFO_LEVEL), .BUSY(BUSY)
`ifdef REQ_TIMEOUT_EN
    , .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] wdata;
    logic [15:0] dout;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];
  vec_t table_v[6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (MEM_RE && MEM_WE) begin
      tests++;
      fails++;
      $display("FAIL re_we_exclusive: got RE=1 WE=1 expected at most one");
    end
  end

  task automatic push(input vec_t v, input bit acc);
    HOST_VALID = 1'b1;
    HOST_WR    = v.wr;
    HOST_BANK  = v.bank;
    HOST_ROW   = v.row;
    HOST_COL   = v.col;
    HOST_WDATA = v.wdata;
    if (acc) exp_q.push_back(v);
    tick();
    HOST_VALID = 1'b0;
  endtask

  // Controller model: walks ACTIVE -> READ/WRITE -> IDLE and checks every phase against the scoreboard
  task automatic serve();
    vec_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    MEM_RDY = 1'b1;
    for (int k = 0; k < 20 && !(MEM_RE || MEM_WE); k++) tick();
    if (!(MEM_RE || MEM_WE)) begin
      chk("issue_wait", 32'd0, 32'd1);
      return;
    end
    chk("row_adr", MEM_ADR, e.row);
    chk("row_bdr", MEM_BDR, e.bank);
    chk("row_we", MEM_WE, e.wr);
    chk("row_re", MEM_RE, !e.wr);
    chk("row_din", MEM_DIN, e.wdata);
    MEM_RDY = 1'b0;
    tick();
    chk("gap_adr", MEM_ADR, {4'b0, e.col});
    chk("gap_strobe", {MEM_WE, MEM_RE}, {e.wr, !e.wr});
    MEM_RDY = 1'b1;
    tick();
    chk("col_adr", MEM_ADR, {4'b0, e.col});
    chk("col_strobe", {MEM_WE, MEM_RE}, {e.wr, !e.wr});
    chk("col_din", MEM_DIN, e.wdata);
    MEM_RDY = 1'b0;
    tick();
    chk("wait_outputs", {MEM_WE, MEM_RE, MEM_ADR, MEM_DIN}, 32'd0);
    MEM_DOUT = e.dout;
    MEM_RDY = 1'b1;
    tick();
    chk("rd_valid", RD_VALID, !e.wr);
    if (!e.wr) chk("rd_data", RD_DATA, e.dout);
    MEM_DOUT = '0;
    tick();
    chk("rd_valid_pulse", RD_VALID, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   rv;

    table_v[0] = '{wr: 1'b1, bank: 2'd2, row: 13'h1ABC, col: 9'h005, wdata: 16'hBEEF, dout: 16'h0000};
    table_v[1] = '{wr: 1'b0, bank: 2'd0, row: 13'h0010, col: 9'h1FF, wdata: 16'h0000, dout: 16'h1234};
    table_v[2] = '{wr: 1'b1, bank: 2'd3, row: 13'h1FFF, col: 9'h1FF, wdata: 16'hFFFF, dout: 16'h0000};
    table_v[3] = '{wr: 1'b0, bank: 2'd1, row: 13'h0000, col: 9'h000, wdata: 16'h5A5A, dout: 16'hFFFF};
    table_v[4] = '{wr: 1'b0, bank: 2'd3, row: 13'h0AAA, col: 9'h155, wdata: 16'h0000, dout: 16'h8001};
    table_v[5] = '{wr: 1'b1, bank: 2'd1, row: 13'h1555, col: 9'h0AA, wdata: 16'h0001, dout: 16'h0000};

    repeat (3) tick();
    chk("rst_ready", HOST_READY, 1'b0);
    chk("rst_level", FIFO_LEVEL, 3'd0);
    chk("rst_mem", {MEM_RE, MEM_WE, MEM_ADR, MEM_BDR, MEM_DIN}, 32'd0);
    chk("rst_busy_rd", {BUSY, RD_VALID, RD_DATA}, 32'd0);
`ifdef REQ_TIMEOUT_EN
    chk("rst_err", ERR, 1'b0);
`endif
    NRST = 1'b1;
    tick();
    chk("ready_after_rst", HOST_READY, 1'b1);

    for (int i = 0; i < 6; i++) begin
      push(table_v[i], 1'b1);
      serve();
    end

    MEM_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = '{wr: i[0], bank: 2'(i), row: 13'(16'h0100 + i), col: 9'(i * 3),
            wdata: 16'(16'hA000 + i), dout: 16'(16'hC000 + i)};
      push(v, i < 4);
      chk("full_level", FIFO_LEVEL, (i < 4) ? 3'(i + 1) : 3'd4);
      chk("full_ready", HOST_READY, i < 3);
    end
    for (int i = 0; i < 4; i++) serve();
    chk("drained_level", FIFO_LEVEL, 3'd0);

    for (int r = 0; r < 5; r++) begin
      MEM_RDY = 1'b0;
      rv = $urandom;
      v = '{wr: rv[0], bank: rv[2:1], row: rv[15:3], col: rv[24:16], wdata: rv[31:16], dout: 16'(rv ^ 32'h5555)};
      push(v, 1'b1);
      chk("wrap_level_push", FIFO_LEVEL, 3'd1);
      rv = $urandom;
      v = '{wr: rv[0], bank: rv[2:1], row: rv[15:3], col: rv[24:16], wdata: rv[31:16], dout: 16'(rv ^ 32'hAAAA)};
      MEM_RDY = 1'b1;
      push(v, 1'b1);
      chk("wrap_level_pushpop", FIFO_LEVEL, 3'd1);
      serve();
      serve();
    end

    MEM_RDY = 1'b0;
    v = '{wr: 1'b0, bank: 2'd1, row: 13'h0123, col: 9'h045, wdata: 16'h0, dout: 16'hDEAD};
    push(v, 1'b0);
    push(v, 1'b0);
    MEM_RDY = 1'b1;
    tick();
    MEM_RDY = 1'b0;
    tick();
    MEM_RDY = 1'b1;
    tick();
    chk("pre_rst_col_re", MEM_RE, 1'b1);
    NRST = 1'b0;
    #1;
    chk("rst_mid_strobe", {MEM_RE, MEM_WE}, 2'b00);
    chk("rst_mid_level", FIFO_LEVEL, 3'd0);
    chk("rst_mid_busy", BUSY, 1'b0);
    tick();
    NRST = 1'b1;
    rv = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (RD_VALID) rv++;
    end
    chk("rst_no_rd_valid", rv, 0);
    chk("rst_no_issue", {MEM_RE, MEM_WE, BUSY}, 3'b000);

    v = '{wr: 1'b1, bank: 2'd2, row: 13'h0777, col: 9'h011, wdata: 16'h4321, dout: 16'h0};
`ifdef REQ_TIMEOUT_EN
    MEM_RDY = 1'b1;
    push(v, 1'b0);
    tick();
    chk("to_busy", BUSY, 1'b1);
    repeat (70) tick();
    chk("to_err", ERR, 1'b1);
    chk("to_idle", {BUSY, MEM_WE, MEM_RE}, 3'b000);
    v.wdata = 16'h9876;
    push(v, 1'b1);
    serve();
    chk("to_err_sticky", ERR, 1'b1);
`else
    MEM_RDY = 1'b1;
    push(v, 1'b1);
    repeat (70) tick();
    chk("no_to_busy", BUSY, 1'b1);
    chk("no_to_we", MEM_WE, 1'b1);
    serve();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
